// File: rtl/regfile_read_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_pkg
// Description : Shared geometry and FSM state type for the register-file
//               read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int WIDTH  = 16;
    localparam int NREG   = 16;
    localparam int ADDR_W = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_sequencer_decoder.sv
`default_nettype none
// ============================================================================
// Module      : read_decoder
// Description : Register address to one-hot word-line decoder. With ZERO_REG
//               set, register 0 is hard-wired and its word line never fires.
// Revision    : 1.0 - initial release
// ============================================================================
module read_decoder
    import regfile_pkg::*;
#(
    parameter int NREG     = regfile_pkg::NREG,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NREG)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   onehot
);

    // One-hot decode, masking the hard-wired zero register
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            onehot[i] = (addr == ADDR_W'(i));
        end
        if (ZERO_REG != 0) begin
            onehot[0] = 1'b0;
        end
    end

endmodule : read_decoder
`default_nettype wire

// File: rtl/regfile_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_sequencer
// Description : Two-port read controller for the bitline register file.
//               Latches a read request, holds one-hot word lines for
//               SETTLE_CYCLES, captures both bitlines (with same-edge write
//               bypass) and returns the operands over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_sequencer
#(
    parameter int WIDTH         = regfile_pkg::WIDTH,
    parameter int NREG          = regfile_pkg::NREG,
    parameter int SETTLE_CYCLES = 1,
    parameter int ZERO_REG      = 1,
    localparam int ADDR_W       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [NREG-1:0]   ReadEnable1,
    output logic [NREG-1:0]   ReadEnable2,
    input  logic [WIDTH-1:0]  Bitline1,
    input  logic [WIDTH-1:0]  Bitline2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2
);
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREG-1:0]     re1_q, re1_d, re2_q, re2_d;
    logic [WIDTH-1:0]    rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [NREG-1:0]     dec1, dec2;
    logic [WIDTH-1:0]    cap1, cap2;

    // Decode the incoming addresses so word lines are registered on accept
    read_decoder #(.NREG(NREG), .ZERO_REG(ZERO_REG)) u_dec1 (
        .addr   (src1),
        .onehot (dec1)
    );

    read_decoder #(.NREG(NREG), .ZERO_REG(ZERO_REG)) u_dec2 (
        .addr   (src2),
        .onehot (dec2)
    );

    // Capture muxes: zero register wins, then same-edge write, then bitline
    always_comb begin
        cap1 = Bitline1;
        cap2 = Bitline2;
        if ((ZERO_REG != 0) && (src1_q == '0)) begin
            cap1 = '0;
        end else if (wr_en && (wr_addr == src1_q)) begin
            cap1 = wr_data;
        end
        if ((ZERO_REG != 0) && (src2_q == '0)) begin
            cap2 = '0;
        end else if (wr_en && (wr_addr == src2_q)) begin
            cap2 = wr_data;
        end
    end

    // Next-state and registered-output computation for IDLE -> DRIVE -> RESP
    always_comb begin
        state_d     = state_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        cnt_d       = cnt_q;
        re1_d       = re1_q;
        re2_d       = re2_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src1_d      = src1;
                    src2_d      = src2;
                    cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                    re1_d       = dec1;
                    re2_d       = dec2;
                    req_ready_d = 1'b0;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    rdata1_d    = cap1;
                    rdata2_d    = cap2;
                    re1_d       = '0;
                    re2_d       = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                re1_d       = '0;
                re2_d       = '0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops word lines immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            src1_q      <= '0;
            src2_q      <= '0;
            cnt_q       <= '0;
            re1_q       <= '0;
            re2_q       <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            cnt_q       <= cnt_d;
            re1_q       <= re1_d;
            re2_q       <= re2_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign ReadEnable1 = re1_q;
    assign ReadEnable2 = re2_q;
    assign rdata1      = rdata1_q;
    assign rdata2      = rdata2_q;

endmodule : regfile_read_sequencer
`default_nettype wire
